// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_mapper
// Purpose  : Player-input front end for arcade cores. Merges PS/2 key events
//            and per-player joystick words into registered per-player
//            buttons with rotation remap, opposing-direction filtering,
//            autofire, and fixed-width coin pulses.
// Revision : 1.0 - initial release
// ============================================================================
module arcade_input_mapper #(
   parameter int PLAYERS      = 2,
   parameter int COIN_PULSE   = 240000,
   parameter int AUTOFIRE_DIV = 600000,
   parameter int SOCD         = 1
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic [10:0]             ps2_key,
   input  logic [PLAYERS*16-1:0]   joy_in,
   input  logic                    rotate,
   input  logic [PLAYERS-1:0]      autofire_en,
   output logic [PLAYERS*5-1:0]    btn_out,
   output logic [PLAYERS-1:0]      start_out,
   output logic [1:0]              coin_out,
   output logic                    test_out
);

   localparam int CW = $clog2(COIN_PULSE + 1);
   localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
   localparam logic [CW-1:0] C_COIN_LOAD = CW'(COIN_PULSE);
   localparam logic [AW-1:0] C_AF_LAST   = AW'(AUTOFIRE_DIV - 1);
   localparam bit            C_P1_KEYS   = (PLAYERS > 1);

   // Event detection
   logic primed_q, primed_d;
   logic old_tgl_q, old_tgl_d;
   logic key_event;

   // Key latches: players 0 and 1 only; dir bits {up, down, left, right}
   logic [1:0][3:0] key_dir_q, key_dir_d;
   logic [1:0]      key_fire_q, key_fire_d;
   logic [1:0]      key_start_q, key_start_d;
   logic [1:0]      key_coin_q, key_coin_d;
   logic            key_test_q, key_test_d;

   // Autofire phase generator
   logic [AW-1:0]   af_cnt_q, af_cnt_d;
   logic            phase_q, phase_d;

   // Coin stretchers
   logic [1:0]          coin_src;
   logic [1:0]          coin_prev_q, coin_prev_d;
   logic [1:0][CW-1:0]  coin_cnt_q, coin_cnt_d;
   logic [1:0]          coin_q, coin_d;

   // Output registers
   logic [PLAYERS*5-1:0] btn_q, btn_d;
   logic [PLAYERS-1:0]   start_q, start_d;
   logic                 test_q, test_d;

   // Detect a toggle on ps2_key[10] and decode the scan code into the key latches.
   // The first cycle after reset only loads old_tgl (primed_q=0 blocks the event).
   always_comb begin
      primed_d    = 1'b1;
      old_tgl_d   = ps2_key[10];
      key_event   = primed_q & (old_tgl_q != ps2_key[10]);
      key_dir_d   = key_dir_q;
      key_fire_d  = key_fire_q;
      key_start_d = key_start_q;
      key_coin_d  = key_coin_q;
      key_test_d  = key_test_q;
      if (key_event) begin
         case (ps2_key[7:0])
            // extended flag is a don't-care for these
            8'h75: key_dir_d[0][3] = ps2_key[9];
            8'h72: key_dir_d[0][2] = ps2_key[9];
            8'h6B: key_dir_d[0][1] = ps2_key[9];
            8'h74: key_dir_d[0][0] = ps2_key[9];
            8'h14: key_fire_d[0]   = ps2_key[9];
            // the rest require a non-extended code
            8'h29: if (!ps2_key[8]) key_fire_d[0]  = ps2_key[9];
            8'h05,
            8'h16: if (!ps2_key[8]) key_start_d[0] = ps2_key[9];
            8'h2D: if (!ps2_key[8] && C_P1_KEYS) key_dir_d[1][3] = ps2_key[9];
            8'h2B: if (!ps2_key[8] && C_P1_KEYS) key_dir_d[1][2] = ps2_key[9];
            8'h23: if (!ps2_key[8] && C_P1_KEYS) key_dir_d[1][1] = ps2_key[9];
            8'h34: if (!ps2_key[8] && C_P1_KEYS) key_dir_d[1][0] = ps2_key[9];
            8'h1C: if (!ps2_key[8] && C_P1_KEYS) key_fire_d[1]   = ps2_key[9];
            8'h06,
            8'h1E: if (!ps2_key[8] && C_P1_KEYS) key_start_d[1]  = ps2_key[9];
            8'h2E: if (!ps2_key[8]) key_coin_d[0] = ps2_key[9];
            8'h36: if (!ps2_key[8]) key_coin_d[1] = ps2_key[9];
            8'h2C: if (!ps2_key[8]) key_test_d    = ps2_key[9];
            default: ;
         endcase
      end
   end

   // Free-running autofire counter; the phase flips each time it wraps.
   always_comb begin
      af_cnt_d = af_cnt_q + AW'(1);
      phase_d  = phase_q;
      if (af_cnt_q == C_AF_LAST) begin
         af_cnt_d = '0;
         phase_d  = ~phase_q;
      end
   end

   // Per-player merge, rotation remap, opposing-direction filter and autofire gate.
   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [3:0] kdir;
      logic       kfire;
      logic       kstart;
      logic [3:0] raw_dir;
      logic [3:0] rot_dir;
      logic [3:0] filt_dir;
      logic       fire;
      logic       unused_joy_bits;

      if (p < 2) begin : g_keys
         assign kdir   = key_dir_q[p];
         assign kfire  = key_fire_q[p];
         assign kstart = key_start_q[p];
      end else begin : g_no_keys
         assign kdir   = 4'b0000;
         assign kfire  = 1'b0;
         assign kstart = 1'b0;
      end

      // Rotation maps up<-left, down<-right, left<-down, right<-up; SOCD follows it.
      always_comb begin
         raw_dir = kdir | joy_in[16*p +: 4];
         rot_dir = rotate ? {raw_dir[1], raw_dir[0], raw_dir[2], raw_dir[3]} : raw_dir;
         filt_dir = rot_dir;
         if (SOCD != 0) begin
            if (rot_dir[1] && rot_dir[0]) filt_dir[1:0] = 2'b00;
            if (rot_dir[3] && rot_dir[2]) filt_dir[3:2] = 2'b00;
         end
         fire = (kfire | joy_in[16*p+4]) & (autofire_en[p] ? phase_q : 1'b1);
      end

      assign btn_d[5*p +: 5] = {fire, filt_dir};
      assign start_d[p]      = kstart | joy_in[16*p+5];
      assign unused_joy_bits = ^{joy_in[16*p+8 +: 8], joy_in[16*p+6]};
   end

   assign test_d = key_test_q;

   // Coin stretchers: an idle slot loads on a source rising edge, then counts down.
   always_comb begin
      coin_src = key_coin_q;
      for (int p = 0; p < PLAYERS; p++) begin
         coin_src[p % 2] = coin_src[p % 2] | joy_in[16*p+7];
      end
      coin_prev_d = coin_src;
      for (int s = 0; s < 2; s++) begin
         coin_cnt_d[s] = coin_cnt_q[s];
         if (coin_cnt_q[s] != '0) begin
            coin_cnt_d[s] = coin_cnt_q[s] - CW'(1);
         end else if (coin_src[s] && !coin_prev_q[s]) begin
            coin_cnt_d[s] = C_COIN_LOAD;
         end
         coin_d[s] = (coin_cnt_d[s] != '0);
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         primed_q    <= 1'b0;
         old_tgl_q   <= 1'b0;
         key_dir_q   <= '0;
         key_fire_q  <= '0;
         key_start_q <= '0;
         key_coin_q  <= '0;
         key_test_q  <= 1'b0;
         af_cnt_q    <= '0;
         phase_q     <= 1'b1;
         coin_prev_q <= '0;
         coin_cnt_q  <= '0;
         coin_q      <= '0;
         btn_q       <= '0;
         start_q     <= '0;
         test_q      <= 1'b0;
      end else begin
         primed_q    <= primed_d;
         old_tgl_q   <= old_tgl_d;
         key_dir_q   <= key_dir_d;
         key_fire_q  <= key_fire_d;
         key_start_q <= key_start_d;
         key_coin_q  <= key_coin_d;
         key_test_q  <= key_test_d;
         af_cnt_q    <= af_cnt_d;
         phase_q     <= phase_d;
         coin_prev_q <= coin_prev_d;
         coin_cnt_q  <= coin_cnt_d;
         coin_q      <= coin_d;
         btn_q       <= btn_d;
         start_q     <= start_d;
         test_q      <= test_d;
      end
   end

   assign btn_out   = btn_q;
   assign start_out = start_q;
   assign coin_out  = coin_q;
   assign test_out  = test_q;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_arcade_input_mapper
// Purpose  : Directed self-checking bench for arcade_input_mapper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arcade_input_mapper;

   localparam int PLAYERS      = 2;
   localparam int COIN_PULSE   = 5;
   localparam int AUTOFIRE_DIV = 4;

   logic                  clk_sys = 1'b0;
   logic                  reset_n;
   logic [10:0]           ps2_key;
   logic [PLAYERS*16-1:0] joy_in;
   logic                  rotate;
   logic [PLAYERS-1:0]    autofire_en;
   logic [PLAYERS*5-1:0]  btn_out;
   logic [PLAYERS-1:0]    start_out;
   logic [1:0]            coin_out;
   logic                  test_out;

   int n_checks = 0;
   int n_fail   = 0;

   arcade_input_mapper #(
      .PLAYERS      (PLAYERS),
      .COIN_PULSE   (COIN_PULSE),
      .AUTOFIRE_DIV (AUTOFIRE_DIV),
      .SOCD         (1)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ps2_key     (ps2_key),
      .joy_in      (joy_in),
      .rotate      (rotate),
      .autofire_en (autofire_en),
      .btn_out     (btn_out),
      .start_out   (start_out),
      .coin_out    (coin_out),
      .test_out    (test_out)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic send_key(input logic pressed, input logic [8:0] code);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   task automatic test_reset;
      reset_n     = 1'b0;
      ps2_key     = {1'b1, 1'b1, 9'h175};
      joy_in      = '0;
      rotate      = 1'b0;
      autofire_en = '0;
      tick(2);
      n_checks++;
      if ({test_out, coin_out, start_out, btn_out} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected 0", {test_out, coin_out, start_out, btn_out});
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         n_checks++;
         if ({test_out, coin_out, start_out, btn_out} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_release cycle %0d: got %h expected 0", k,
                     {test_out, coin_out, start_out, btn_out});
         end
      end
   endtask

   task automatic test_key_up;
      send_key(1'b1, 9'h175);
      tick();
      n_checks++;
      if (btn_out[3] !== 1'b0) begin
         n_fail++; $display("FAIL key_up_lat1: got %b expected 0", btn_out[3]);
      end
      tick();
      n_checks++;
      if (btn_out[3] !== 1'b1) begin
         n_fail++; $display("FAIL key_up_press: got %b expected 1", btn_out[3]);
      end
      send_key(1'b0, 9'h175);
      tick();
      n_checks++;
      if (btn_out[3] !== 1'b1) begin
         n_fail++; $display("FAIL key_up_rel_lat1: got %b expected 1", btn_out[3]);
      end
      tick();
      n_checks++;
      if (btn_out[3] !== 1'b0) begin
         n_fail++; $display("FAIL key_up_release: got %b expected 0", btn_out[3]);
      end
   endtask

   // obs = {test, start[1:0], btn[9:0]}; idx -1 means the code must be ignored
   task automatic test_key_map;
      logic [8:0]  codes [18];
      int          idx   [18];
      logic [12:0] exp_v;
      codes = '{9'h075, 9'h072, 9'h16B, 9'h074, 9'h029, 9'h114, 9'h005, 9'h016, 9'h02D,
                9'h02B, 9'h023, 9'h034, 9'h01C, 9'h006, 9'h01E, 9'h02C, 9'h129, 9'h0FF};
      idx   = '{3, 2, 1, 0, 4, 4, 10, 10, 8, 7, 6, 5, 9, 11, 11, 12, -1, -1};
      for (int i = 0; i < 18; i++) begin
         exp_v = (idx[i] >= 0) ? (13'd1 << idx[i]) : 13'd0;
         send_key(1'b1, codes[i]);
         tick(2);
         n_checks++;
         if ({test_out, start_out, btn_out} !== exp_v) begin
            n_fail++;
            $display("FAIL key_map press %h: got %h expected %h", codes[i],
                     {test_out, start_out, btn_out}, exp_v);
         end
         send_key(1'b0, codes[i]);
         tick(2);
         n_checks++;
         if ({test_out, start_out, btn_out} !== 13'd0) begin
            n_fail++;
            $display("FAIL key_map release %h: got %h expected 0", codes[i],
                     {test_out, start_out, btn_out});
         end
      end
   endtask

   task automatic test_rotation_socd;
      logic [15:0] joys [8];
      logic        rots [8];
      logic [4:0]  exps [8];
      joys = '{16'h0002, 16'h0001, 16'h0008, 16'h0004, 16'h0003, 16'h000C, 16'h0003, 16'h0030};
      rots = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exps = '{5'b01000, 5'b00100, 5'b00001, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
      for (int i = 0; i < 8; i++) begin
         rotate = rots[i];
         joy_in = {16'h0000, joys[i]};
         tick();
         n_checks++;
         if (btn_out[4:0] !== exps[i]) begin
            n_fail++;
            $display("FAIL rot_socd %0d: got %b expected %b", i, btn_out[4:0], exps[i]);
         end
      end
      n_checks++;
      if (start_out !== 2'b01) begin
         n_fail++; $display("FAIL joy_start: got %b expected 01", start_out);
      end
      // player 1 joystick lands in its own slice
      rotate = 1'b0;
      joy_in = {16'h0011, 16'h0000};
      tick();
      n_checks++;
      if (btn_out !== 10'b10001_00000) begin
         n_fail++; $display("FAIL joy_p1: got %b expected 1000100000", btn_out);
      end
      // key event and joystick in the same cycle: joystick shows first, then both OR'd
      joy_in = {16'h0000, 16'h0002};
      send_key(1'b1, 9'h074);
      tick();
      n_checks++;
      if (btn_out[4:0] !== 5'b00010) begin
         n_fail++; $display("FAIL simul_lat1: got %b expected 00010", btn_out[4:0]);
      end
      tick();
      n_checks++;
      if (btn_out[4:0] !== 5'b00000) begin
         n_fail++; $display("FAIL simul_socd: got %b expected 00000", btn_out[4:0]);
      end
      joy_in = '0;
      send_key(1'b0, 9'h074);
      tick(2);
      n_checks++;
      if (btn_out !== 10'd0) begin
         n_fail++; $display("FAIL simul_clear: got %b expected 0", btn_out);
      end
   endtask

   task automatic test_coin_joy;
      logic exp_c;
      joy_in = {16'h0000, 16'h0080};
      for (int k = 1; k <= 20; k++) begin
         tick();
         exp_c = (k <= COIN_PULSE);
         n_checks++;
         if (coin_out !== {1'b0, exp_c}) begin
            n_fail++;
            $display("FAIL coin_hold cycle %0d: got %b expected %b", k, coin_out, {1'b0, exp_c});
         end
      end
      joy_in = '0;
      tick(3);
      joy_in = {16'h0080, 16'h0000};
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_c = (k <= COIN_PULSE);
         n_checks++;
         if (coin_out !== {exp_c, 1'b0}) begin
            n_fail++;
            $display("FAIL coin_slot2 cycle %0d: got %b expected %b", k, coin_out, {exp_c, 1'b0});
         end
      end
      joy_in = '0;
      tick(3);
      joy_in = {16'h0000, 16'h0080};
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_c = (k <= COIN_PULSE);
         n_checks++;
         if (coin_out !== {1'b0, exp_c}) begin
            n_fail++;
            $display("FAIL coin_repress cycle %0d: got %b expected %b", k, coin_out, {1'b0, exp_c});
         end
      end
      joy_in = '0;
      // key coin: event latched, then pulse starts one cycle later
      send_key(1'b1, 9'h036);
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_c = (k >= 2) && (k <= COIN_PULSE + 1);
         n_checks++;
         if (coin_out !== {exp_c, 1'b0}) begin
            n_fail++;
            $display("FAIL coin_key cycle %0d: got %b expected %b", k, coin_out, {exp_c, 1'b0});
         end
      end
      send_key(1'b0, 9'h036);
      tick(3);
   endtask

   task automatic test_autofire;
      logic s [17];
      int   last;
      int   ntr;
      autofire_en = 2'b01;
      joy_in      = {16'h0000, 16'h0010};
      tick();
      for (int k = 0; k < 17; k++) begin
         tick();
         s[k] = btn_out[4];
      end
      last = -1;
      ntr  = 0;
      for (int k = 1; k < 17; k++) begin
         if (s[k] != s[k-1]) begin
            if (last >= 0) begin
               n_checks++;
               if (k - last != AUTOFIRE_DIV) begin
                  n_fail++;
                  $display("FAIL autofire_period: got %0d expected %0d", k - last, AUTOFIRE_DIV);
               end
            end
            last = k;
            ntr++;
         end
      end
      n_checks++;
      if (ntr < 3) begin
         n_fail++; $display("FAIL autofire_toggles: got %0d expected >=3", ntr);
      end
      autofire_en = 2'b00;
      tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++;
         if (btn_out[4] !== 1'b1) begin
            n_fail++; $display("FAIL autofire_off cycle %0d: got %b expected 1", k, btn_out[4]);
         end
      end
      joy_in = '0;
      tick(2);
   endtask

   task automatic test_reset_mid;
      send_key(1'b1, 9'h02E);
      tick();
      send_key(1'b1, 9'h074);
      tick(2);
      n_checks++;
      if ({coin_out[0], btn_out[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL pre_reset: got %b expected 11", {coin_out[0], btn_out[0]});
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({test_out, coin_out, start_out, btn_out} !== 15'h0) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected 0", {test_out, coin_out, start_out, btn_out});
      end
      tick(2);
      reset_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_checks++;
         if ({test_out, coin_out, start_out, btn_out} !== 15'h0) begin
            n_fail++;
            $display("FAIL post_reset cycle %0d: got %h expected 0", k,
                     {test_out, coin_out, start_out, btn_out});
         end
      end
      send_key(1'b1, 9'h074);
      tick(2);
      n_checks++;
      if (btn_out !== 10'b00000_00001) begin
         n_fail++; $display("FAIL post_reset_event: got %b expected 0000000001", btn_out);
      end
   endtask

   initial begin
      test_reset();
      test_key_up();
      test_key_map();
      test_rotation_socd();
      test_coin_joy();
      test_autofire();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised player-input front end for arcade cores.
- Merges PS/2 key events and per-player joystick words into registered per-player direction/fire/start buttons, plus coin and test outputs.
- Adds the following over the current per-core inline logic:
  - N-player scaling.
  - Optional rotation remap.
  - Opposing-direction (SOCD) filtering.
  - Autofire.
  - Fixed-width coin pulse stretching.
- Sits between hps_io and the game core.

Parameters:
- PLAYERS, 2, number of players (1..4).
- COIN_PULSE, 240000, coin output high-time in clk_sys cycles (20 ms at 12 MHz). Must be ≥2.
- AUTOFIRE_DIV, 600000, autofire phase half-period in clk_sys cycles. Must be ≥1.
- SOCD, 1, when 1, simultaneous opposing directions cancel.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scan code
- joy_in  in  PLAYERS*16  player p at [16p+15:16p]; bits 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 7 coin
- rotate  in  1  1 = rotated remap
- autofire_en  in  PLAYERS  per-player autofire enable
- btn_out  out  PLAYERS*5  player p at [5p+4:5p] = {fire, up, down, left, right}
- start_out  out  PLAYERS  start per player
- coin_out  out  2  stretched coin pulses, slots 1/2
- test_out  out  1  test key held

Behaviour:
- Reset: asynchronous, active-low. All key latches, counters, btn_out, start_out, coin_out and test_out go to 0; autofire phase goes to 1; primed goes to 0.
- Event detect:
  - Register old_tgl from ps2_key[10].
  - Event = primed & (old_tgl != ps2_key[10]).
  - The first cycle after reset release sets primed=1 and loads old_tgl with no decode, so there are no spurious events.
- Key decode on event, latching key state = ps2_key[9]. X = extended-flag don't-care.
  - P0: X75 up, X72 down, X6B left, X74 right, 029 or X14 fire, 005 or 016 start.
  - P1: 02D up, 02B down, 023 left, 034 right, 01C fire, 006 or 01E start.
  - 02E coin slot 1; 036 coin slot 2; 02C test.
  - Unlisted codes are ignored.
  - P1 keys are ignored when PLAYERS=1. Players 2..3 are joystick-only.
- Raw per player: raw_dir = key_dir | joy_dir; raw_fire = key_fire | joy bit 4; raw_start = key_start | joy bit 5.
- Rotation (rotate=1): up←raw left, down←raw right, left←raw down, right←raw up. rotate=0 passes through.
- SOCD, applied after rotation: left&right → both 0; up&down → both 0.
- Autofire:
  - A single free-running counter counts 0..AUTOFIRE_DIV-1; phase toggles at wrap.
  - fire = raw_fire & (autofire_en[p] ? phase : 1).
  - Phase is not re-synchronised on press.
- Coin stretcher, per slot:
  - Source slot 1 = key 02E | joy0 bit 7 | joy2 bit 7.
  - Source slot 2 = key 036 | joy1 bit 7 | joy3 bit 7.
  - A rising edge of the source while idle loads the counter; coin_out goes high the next cycle for exactly COIN_PULSE cycles.
  - Rising edges while active are ignored.
  - A held source does not retrigger; it must fall and rise again.
- Latency:
  - Joystick to outputs: 1 cycle.
  - PS/2 event to outputs: 2 cycles (latch, then output register).
- Simultaneous events: the key event and joystick changes in the same cycle are both honoured through the OR.
- Reset mid-pulse aborts the coin pulse and clears all latched keys; no resume after release.

Test Plan:
- Reset release with ps2_key[10]=1 steady for 10 cycles → no event; all outputs 0.
- Toggle ps2_key[10] with {pressed=1, 0x175} → btn_out[3] (P0 up)=1 two cycles later. Toggle again with pressed=0 → 0 two cycles later.
- rotate=1, joy_in[1]=1 (P0 left) → btn_out[3] (up)=1 after 1 cycle. Add joy_in[0] with rotate=0 → left and right both 0 (SOCD=1).
- COIN_PULSE=5: joy_in bit 7 held 20 cycles → coin_out[0] high exactly 5 cycles starting 1 cycle after the rise, no retrigger. Release and re-press → second 5-cycle pulse.
- AUTOFIRE_DIV=4, autofire_en=1, fire held → btn_out[4] toggles every 4 cycles. autofire_en=0 → steady 1.
- Assert reset_n=0 mid-coin pulse and with a key held → all outputs 0 asynchronously; stays 0 after release until a new event.
